// File: rtl/brain_cmd_pkg.sv
// ============================================================================
// Module     : brain_cmd_pkg
// Description: Shared types and constants for the UART command executor:
//              FSM state encoding, opcode/response characters and
//              nibble<->ASCII helper functions.
//              Optional build macro: WRITE_VERIFY_EN (adds verify states).
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package brain_cmd_pkg;

  localparam int DWIDTH_DEF = 32;
  localparam int AWIDTH_DEF = 12;
  localparam int HEX_DIGITS = DWIDTH_DEF / 4;

  localparam logic [7:0] OP_R    = 8'h52;  // 'R'
  localparam logic [7:0] OP_W    = 8'h57;  // 'W'
  localparam logic [7:0] RSP_K   = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_E   = 8'h45;  // 'E'
  localparam logic [7:0] RSP_V   = 8'h56;  // 'V'
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_RD_ADDR   = 4'd1,
    ST_RD_WAIT   = 4'd2,
    ST_TX_HEX    = 4'd3,
    ST_TX_CR     = 4'd4,
    ST_TX_LF     = 4'd5,
    ST_WR_DATA   = 4'd6,
    ST_WR_COMMIT = 4'd7,
`ifdef WRITE_VERIFY_EN
    ST_VF_RD     = 4'd9,
    ST_VF_WAIT   = 4'd10,
`endif
    ST_TX_ACK    = 4'd8
  } state_t;

  // Returns {valid, nibble}; valid only for 0-9, A-F, a-f.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [7:0] t;
    t = 8'h00;
    if (c >= 8'h30 && c <= 8'h39) begin
      t = c - 8'h30;
      return {1'b1, t[3:0]};
    end else if (c >= 8'h41 && c <= 8'h46) begin
      t = c - 8'h37;
      return {1'b1, t[3:0]};
    end else if (c >= 8'h61 && c <= 8'h66) begin
      t = c - 8'h57;
      return {1'b1, t[3:0]};
    end
    return 5'b0_0000;
  endfunction

  // Uppercase ASCII hex digit for a nibble.
  function automatic logic [7:0] hex_encode(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_cmd_exec_if.sv
// ============================================================================
// Module     : uart_cmd_exec_if
// Description: Bundles the command input, BRAM port and UART TX handshake of
//              the command executor. master = executor, slave = environment.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_cmd_exec_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 12
);
  logic              cmd_valid;
  logic [31:0]       cmd_word;
  logic              cmd_ready;
  logic              cmd_drop;
  logic              bram_we;
  logic [AWIDTH-1:0] bram_addr;
  logic [DWIDTH-1:0] bram_di;
  logic [DWIDTH-1:0] bram_do;
  logic              txstart;
  logic [7:0]        txdata;
  logic              txbusy;
  logic              txdone;

  modport master (
    input  cmd_valid, cmd_word, bram_do, txbusy, txdone,
    output cmd_ready, cmd_drop, bram_we, bram_addr, bram_di, txstart, txdata
  );

  modport slave (
    output cmd_valid, cmd_word, bram_do, txbusy, txdone,
    input  cmd_ready, cmd_drop, bram_we, bram_addr, bram_di, txstart, txdata
  );
endinterface

`default_nettype wire

// File: rtl/uart_cmd_exec_hex_ascii.sv
// ============================================================================
// Module     : hex_ascii
// Description: Combinational multi-lane hex converter. ENCODE=0 decodes
//              ASCII chars to nibbles with a per-lane valid flag; ENCODE=1
//              encodes nibbles to uppercase ASCII (always valid).
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_ascii
  import brain_cmd_pkg::*;
#(
  parameter int LANES  = 1,
  parameter bit ENCODE = 1'b0
) (
  input  logic [(ENCODE ? 4 : 8)*LANES-1:0] din,
  output logic [(ENCODE ? 8 : 4)*LANES-1:0] dout,
  output logic [LANES-1:0]                  valid
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    if (ENCODE) begin : g_enc
      assign dout[8*i +: 8] = hex_encode(din[4*i +: 4]);
      assign valid[i]       = 1'b1;
    end else begin : g_dec
      assign {valid[i], dout[4*i +: 4]} = hex_decode(din[8*i +: 8]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_cmd_exec.sv
// ============================================================================
// Module     : uart_cmd_exec
// Description: Executes one 4-char ASCII command per line against a BRAM map
//              ('Rxxx' read, 'Wxxx' + data lines write) and answers over the
//              UART TX byte handshake.
//              Optional build macro: WRITE_VERIFY_EN (read-back after write,
//              'V' response on mismatch).
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_exec
  import brain_cmd_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_cmd_exec_if.master  bus
);

  localparam int N_HEX   = DWIDTH / 4;
  localparam int N_LINES = DWIDTH / 16;
  localparam int HIDX_W  = $clog2(N_HEX);
  localparam int LCNT_W  = (N_LINES > 1) ? $clog2(N_LINES) : 1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [AWIDTH-1:0]   r_addr;
  logic [DWIDTH-1:0]   r_data;
  logic [LCNT_W-1:0]   r_lcnt;
  logic [HIDX_W-1:0]   r_hidx;
  logic [7:0]          r_rsp;
  logic                r_tx_sent;

  logic [15:0]         w_dec_nib;
  logic [3:0]          w_dec_valid;
  logic [7:0]          w_enc_char;
  logic [0:0]          w_enc_valid;
  logic [7:0]          w_op;
  logic                w_is_r;
  logic                w_is_w;
  logic                w_addr_ok;
  logic                w_data_ok;
  logic                w_last_line;
  logic                w_tx_state;
  logic                w_tx_adv;

  hex_ascii #(.LANES(4), .ENCODE(1'b0)) u_dec (
    .din   (bus.cmd_word),
    .dout  (w_dec_nib),
    .valid (w_dec_valid)
  );

  hex_ascii #(.LANES(1), .ENCODE(1'b1)) u_enc (
    .din   (r_data[DWIDTH-1 -: 4]),
    .dout  (w_enc_char),
    .valid (w_enc_valid)
  );

  // Case-fold the opcode by clearing bit 5; a leading 8'h00 never matches.
  assign w_op        = bus.cmd_word[31:24] & 8'hDF;
  assign w_is_r      = (w_op == OP_R);
  assign w_is_w      = (w_op == OP_W);
  assign w_addr_ok   = &w_dec_valid[2:0];
  assign w_data_ok   = &w_dec_valid;
  assign w_last_line = (r_lcnt == LCNT_W'(N_LINES - 1));
  assign w_tx_state  = (r_state == ST_TX_HEX) || (r_state == ST_TX_CR) ||
                       (r_state == ST_TX_LF)  || (r_state == ST_TX_ACK);
  assign w_tx_adv    = w_tx_state && r_tx_sent && bus.txdone;

  assign bus.bram_addr = r_addr;
  assign bus.bram_di   = r_data;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode; commands arriving outside IDLE/WR_DATA are ignored here.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          if (w_is_r && w_addr_ok)      w_state_nxt = ST_RD_ADDR;
          else if (w_is_w && w_addr_ok) w_state_nxt = ST_WR_DATA;
          else                          w_state_nxt = ST_TX_ACK;
        end
      end
      ST_RD_ADDR: w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: w_state_nxt = ST_TX_HEX;
      ST_TX_HEX: begin
        if (w_tx_adv && (r_hidx == HIDX_W'(N_HEX - 1))) w_state_nxt = ST_TX_CR;
      end
      ST_TX_CR:  if (w_tx_adv) w_state_nxt = ST_TX_LF;
      ST_TX_LF:  if (w_tx_adv) w_state_nxt = ST_IDLE;
      ST_TX_ACK: if (w_tx_adv) w_state_nxt = ST_TX_CR;
      ST_WR_DATA: begin
        if (bus.cmd_valid) begin
          if (!w_data_ok)       w_state_nxt = ST_TX_ACK;
          else if (w_last_line) w_state_nxt = ST_WR_COMMIT;
        end
      end
`ifdef WRITE_VERIFY_EN
      ST_WR_COMMIT: w_state_nxt = ST_VF_RD;
      ST_VF_RD:     w_state_nxt = ST_VF_WAIT;
      ST_VF_WAIT:   w_state_nxt = ST_TX_ACK;
`else
      ST_WR_COMMIT: w_state_nxt = ST_TX_ACK;
`endif
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: address/data capture, hex shift-out, line count, TX handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_data    <= '0;
      r_lcnt    <= '0;
      r_hidx    <= '0;
      r_rsp     <= 8'h00;
      r_tx_sent <= 1'b0;
    end else begin
      if (w_tx_state && !r_tx_sent && !bus.txbusy) r_tx_sent <= 1'b1;
      else if (w_tx_adv)                           r_tx_sent <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            r_addr <= AWIDTH'(w_dec_nib[11:0]);
            r_data <= '0;
            r_lcnt <= '0;
            r_rsp  <= RSP_E;
          end
        end
        ST_RD_WAIT: begin
          r_data <= bus.bram_do;
          r_hidx <= '0;
        end
        ST_TX_HEX: begin
          if (w_tx_adv) begin
            r_data <= r_data << 4;
            r_hidx <= r_hidx + 1'b1;
          end
        end
        ST_WR_DATA: begin
          if (bus.cmd_valid) begin
            if (w_data_ok) begin
              r_data <= (r_data << 16) | DWIDTH'(w_dec_nib);
              r_lcnt <= r_lcnt + 1'b1;
            end else begin
              r_rsp  <= RSP_E;
            end
          end
        end
        ST_WR_COMMIT: r_rsp <= RSP_K;
`ifdef WRITE_VERIFY_EN
        ST_VF_WAIT:   r_rsp <= (bus.bram_do == r_data) ? RSP_K : RSP_V;
`endif
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; TXSTART fires once per char while TX is idle.
  always_comb begin
    bus.cmd_ready = (r_state == ST_IDLE) || (r_state == ST_WR_DATA);
    bus.cmd_drop  = bus.cmd_valid && !bus.cmd_ready;
    bus.bram_we   = (r_state == ST_WR_COMMIT);
    bus.txstart   = w_tx_state && !r_tx_sent && !bus.txbusy;
    case (r_state)
      ST_TX_HEX: bus.txdata = w_enc_valid[0] ? w_enc_char : RSP_E;
      ST_TX_CR:  bus.txdata = CHAR_CR;
      ST_TX_LF:  bus.txdata = CHAR_LF;
      ST_TX_ACK: bus.txdata = r_rsp;
      default:   bus.txdata = 8'h00;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_exec.sv
// ============================================================================
// Module     : tb_uart_cmd_exec
// Description: Directed self-checking bench for uart_cmd_exec with a
//              synchronous-read BRAM model and a UART TX byte sink.
//              Optional build macro: WRITE_VERIFY_EN (adds verify-fail case).
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_cmd_exec;

  logic clk = 1'b0;
  logic rst_n;

  uart_cmd_exec_if #(.DWIDTH(32), .AWIDTH(12)) bus ();

  uart_cmd_exec #(.DWIDTH(32), .AWIDTH(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          cmd_cyc = 0;
  int          first_start_cyc = 0;
  int          we_cnt = 0;
  logic [11:0] we_addr;
  logic [31:0] we_di;
  logic [31:0] mem [4096];
  logic [7:0]  tx_q[$];
  int          tx_cnt;
  logic        corrupt = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // BRAM model: one-cycle registered read, optional write corruption.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.cmd_valid) cmd_cyc <= cyc;
    if (bus.bram_we) begin
      mem[bus.bram_addr] <= corrupt ? (bus.bram_di ^ 32'h1) : bus.bram_di;
      we_cnt  <= we_cnt + 1;
      we_addr <= bus.bram_addr;
      we_di   <= bus.bram_di;
    end
    bus.bram_do <= mem[bus.bram_addr];
  end

  // UART TX sink: busy for a few cycles per byte, then a 1-cycle done pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.txbusy <= 1'b0;
      bus.txdone <= 1'b0;
      tx_cnt     <= 0;
    end else begin
      bus.txdone <= 1'b0;
      if (bus.txstart && !bus.txbusy) begin
        if (tx_q.size() == 0) first_start_cyc <= cyc;
        tx_q.push_back(bus.txdata);
        bus.txbusy <= 1'b1;
        tx_cnt     <= 3;
      end else if (bus.txbusy) begin
        if (tx_cnt == 0) begin
          bus.txbusy <= 1'b0;
          bus.txdone <= 1'b1;
        end else begin
          tx_cnt <= tx_cnt - 1;
        end
      end
    end
  end

  task automatic send_cmd(input logic [31:0] w);
    @(negedge clk);
    bus.cmd_word  = w;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_word  = 32'h0;
  endtask

  task automatic wait_tx(input string tag, input int n);
    int ok;
    ok = 0;
    for (int c = 0; c < 2000; c++) begin
      if (tx_q.size() >= n) begin ok = 1; break; end
      @(negedge clk);
    end
    check_eq({tag, "_tx_timeout"}, 64'(ok), 64'd1);
  endtask

  // Waits for the full response (body + CR LF) and compares it byte by byte.
  task automatic expect_resp(input string tag, input string body);
    int ok;
    int n;
    n  = body.len() + 2;
    ok = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (tx_q.size() >= n && bus.cmd_ready && !bus.txbusy) begin ok = 1; break; end
    end
    check_eq({tag, "_timeout"}, 64'(ok), 64'd1);
    repeat (8) @(negedge clk);
    check_eq({tag, "_len"}, 64'(tx_q.size()), 64'(n));
    if (tx_q.size() == n) begin
      for (int i = 0; i < body.len(); i++)
        check_eq($sformatf("%s_b%0d", tag, i), 64'(tx_q[i]), 64'(body[i]));
      check_eq({tag, "_cr"}, 64'(tx_q[n-2]), 64'h0D);
      check_eq({tag, "_lf"}, 64'(tx_q[n-1]), 64'h0A);
    end
    check_eq({tag, "_ready"}, 64'(bus.cmd_ready), 64'd1);
    tx_q.delete();
  endtask

  initial begin
    int we0;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_word  = 32'h0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[12'h000] = 32'h1234ABCD;
    mem[12'h010] = 32'hCAFE0123;

    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_ready",   64'(bus.cmd_ready), 64'd1);
    check_eq("rst_drop",    64'(bus.cmd_drop),  64'd0);
    check_eq("rst_we",      64'(bus.bram_we),   64'd0);
    check_eq("rst_addr",    64'(bus.bram_addr), 64'd0);
    check_eq("rst_di",      64'(bus.bram_di),   64'd0);
    check_eq("rst_txstart", 64'(bus.txstart),   64'd0);
    check_eq("rst_txdata",  64'(bus.txdata),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: plain read
    send_cmd(32'h52303030);                       // "R000"
    wait_tx("rd0", 1);
    check_eq("rd0_latency_ge3", 64'((first_start_cyc - cmd_cyc) >= 3), 64'd1);
    expect_resp("rd0", "1234ABCD");

    // 2: two-line write, then read back
    send_cmd(32'h57304646);                       // "W0FF"
    check_eq("wr_ready_in_wrdata", 64'(bus.cmd_ready), 64'd1);
    send_cmd(32'h44454144);                       // "DEAD"
    check_eq("wr_no_early_we", 64'(we_cnt), 64'd0);
    send_cmd(32'h62656566);                       // "beef"
    #1;
    check_eq("wr_we_pulse", 64'(bus.bram_we),   64'd1);
    check_eq("wr_addr",     64'(bus.bram_addr), 64'h0FF);
    check_eq("wr_di",       64'(bus.bram_di),   64'hDEADBEEF);
    @(negedge clk); #1;
    check_eq("wr_we_1cyc",  64'(bus.bram_we),   64'd0);
    expect_resp("wr_ack", "K");
    check_eq("wr_cnt",      64'(we_cnt),  64'd1);
    check_eq("wr_mem_addr", 64'(we_addr), 64'h0FF);
    check_eq("wr_mem_di",   64'(we_di),   64'hDEADBEEF);
    send_cmd(32'h52304646);                       // "R0FF"
    expect_resp("rd_ff", "DEADBEEF");

    // 3: unknown opcode and short line
    we0 = we_cnt;
    send_cmd(32'h58313233);                       // "X123"
    expect_resp("bad_op", "E");
    send_cmd(32'h00005231);                       // "R1"
    expect_resp("short", "E");
    check_eq("bad_no_we", 64'(we_cnt), 64'(we0));

    // 4: non-hex data line aborts the write
    send_cmd(32'h57303130);                       // "W010"
    send_cmd(32'h31324734);                       // "12G4"
    expect_resp("wr_bad", "E");
    check_eq("wr_bad_no_we", 64'(we_cnt), 64'(we0));
    send_cmd(32'h52303130);                       // "R010"
    expect_resp("rd_10", "CAFE0123");

    // 5: command while transmitting is dropped
    send_cmd(32'h52303030);                       // "R000"
    wait_tx("drop", 2);
    @(negedge clk);
    bus.cmd_word  = 32'h57313233;                 // "W123"
    bus.cmd_valid = 1'b1;
    #1;
    check_eq("drop_pulse", 64'(bus.cmd_drop),  64'd1);
    check_eq("drop_ready", 64'(bus.cmd_ready), 64'd0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_word  = 32'h0;
    #1;
    check_eq("drop_1cyc", 64'(bus.cmd_drop), 64'd0);
    expect_resp("drop_rd", "1234ABCD");
    check_eq("drop_no_we", 64'(we_cnt), 64'(we0));

    // 6: reset in the middle of the hex response
    send_cmd(32'h52303030);                       // "R000"
    wait_tx("rst_mid", 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_txstart", 64'(bus.txstart),   64'd0);
    check_eq("rstmid_ready",   64'(bus.cmd_ready), 64'd1);
    check_eq("rstmid_addr",    64'(bus.bram_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check_eq("rstmid_no_more_tx", 64'(tx_q.size()), 64'd3);
    tx_q.delete();
    send_cmd(32'h72306666);                       // "r0ff"
    expect_resp("post_rst", "DEADBEEF");

`ifdef WRITE_VERIFY_EN
    corrupt = 1'b1;
    send_cmd(32'h57303230);                       // "W020"
    send_cmd(32'h30303030);                       // "0000"
    send_cmd(32'h30303031);                       // "0001"
    expect_resp("verify_bad", "V");
    corrupt = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
